// File: rtl/lidar_tile_pkg.sv
// Shared types and defaults for the LiDAR point-cloud tiler.
// Holds the bucket FSM encoding and the saturating drop-counter helper.
package lidar_tile_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int DROP_CNT_W       = 16;
  localparam int DEF_NUM_TILES    = 256;
  localparam int DEF_PTS_PER_TILE = 32;
  localparam int DEF_POINT_W      = 32;
  localparam int DEF_LANES        = 4;

  function automatic logic [DROP_CNT_W-1:0] sat_add_drop(
    input logic [DROP_CNT_W-1:0] acc,
    input logic [7:0]            inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, acc} + (DROP_CNT_W+1)'(inc);
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/tile_slot_allocator.sv
// Per-lane slot assignment for one input beat: same-tile prefix count,
// write enable, overflow drop, and the new count from the last lane of each tile.
module tile_slot_allocator
  import lidar_tile_pkg::*;
#(
  parameter int NUM_TILES    = DEF_NUM_TILES,
  parameter int PTS_PER_TILE = DEF_PTS_PER_TILE,
  parameter int LANES        = DEF_LANES,
  localparam int TILE_W      = $clog2(NUM_TILES),
  localparam int CNT_W       = $clog2(PTS_PER_TILE) + 1,
  localparam int SLOT_W      = $clog2(PTS_PER_TILE)
) (
  input  logic [LANES-1:0]        i_lane_en,
  input  logic [LANES*TILE_W-1:0] i_tile_idx,
  input  logic [LANES*CNT_W-1:0]  i_lane_cnt,
  output logic [LANES*SLOT_W-1:0] o_slot,
  output logic [LANES-1:0]        o_wr_en,
  output logic [LANES-1:0]        o_drop,
  output logic [LANES-1:0]        o_cnt_upd,
  output logic [LANES*CNT_W-1:0]  o_cnt_new
);

  localparam int SUM_W = CNT_W + $clog2(LANES) + 1;
  localparam logic [SUM_W-1:0] PTS_S = SUM_W'(PTS_PER_TILE);

  // NOTE: every output and local gets a default before the loop so no latch is inferred.
  always_comb begin
    logic [SUM_W-1:0] v_slot;
    logic [SUM_W-1:0] v_inc;
    logic             v_last;
    o_slot    = '0;
    o_wr_en   = '0;
    o_drop    = '0;
    o_cnt_upd = '0;
    o_cnt_new = '0;
    v_slot    = '0;
    v_inc     = '0;
    v_last    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      v_slot = SUM_W'(i_lane_cnt[i*CNT_W +: CNT_W]);
      v_last = 1'b1;
      for (int j = 0; j < LANES; j++) begin
        if (i_lane_en[j] && (i_tile_idx[j*TILE_W +: TILE_W] == i_tile_idx[i*TILE_W +: TILE_W])) begin
          if (j < i) v_slot = v_slot + SUM_W'(1);
          if (j > i) v_last = 1'b0;
        end
      end
      v_inc = v_slot + SUM_W'(1);
      if (i_lane_en[i]) begin
        o_wr_en[i]                  = (v_slot < PTS_S);
        o_drop[i]                   = !(v_slot < PTS_S);
        o_slot[i*SLOT_W +: SLOT_W]  = v_slot[SLOT_W-1:0];
        // Only the highest lane of a tile commits the count, so each tile is written once per beat.
        o_cnt_upd[i]                = v_last;
        o_cnt_new[i*CNT_W +: CNT_W] = (v_inc > PTS_S) ? CNT_W'(PTS_PER_TILE) : v_inc[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tile_point_buffer.sv
// Per-tile point bucket: fills tile slot lists from multi-lane beats, then drains
// non-empty tiles in ascending order over a valid/ready stream and clears for the next frame.
module tile_point_buffer
  import lidar_tile_pkg::*;
#(
  parameter int NUM_TILES    = DEF_NUM_TILES,
  parameter int PTS_PER_TILE = DEF_PTS_PER_TILE,
  parameter int POINT_W      = DEF_POINT_W,
  parameter int LANES        = DEF_LANES,
  localparam int TILE_W      = $clog2(NUM_TILES),
  localparam int CNT_W       = $clog2(PTS_PER_TILE) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_en,
  input  logic [LANES*TILE_W-1:0] in_tile_idx,
  input  logic [LANES*POINT_W-1:0] in_point,
  input  logic                    in_frame_end,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [POINT_W-1:0]      out_point,
  output logic [TILE_W-1:0]       out_tile,
  output logic                    out_tile_last,
  output logic                    out_frame_last,
  output logic                    frame_done,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  localparam int SLOT_W  = $clog2(PTS_PER_TILE);
  localparam int ADDR_W  = TILE_W + SLOT_W;
  localparam int DEPTH   = NUM_TILES * PTS_PER_TILE;
  localparam int NDROP_W = $clog2(LANES + 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  state_e r_state, w_state_next;

  logic [CNT_W-1:0]   r_cnt [NUM_TILES];
  logic [POINT_W-1:0] r_mem [DEPTH];
  logic [DROP_CNT_W-1:0] r_drop;

  logic [TILE_W-1:0]  r_scan;
  logic [CNT_W-1:0]   r_slot;
  logic               r_scan_end;
  logic               r_out_valid;
  logic [POINT_W-1:0] r_out_point;
  logic [TILE_W-1:0]  r_out_tile;
  logic               r_out_tile_last;
  logic               r_out_frame_last;

  logic                    w_accept;
  logic [LANES*CNT_W-1:0]  w_lane_cnt;
  logic [LANES*SLOT_W-1:0] w_slot;
  logic [LANES-1:0]        w_wr_en;
  logic [LANES-1:0]        w_drop;
  logic [LANES-1:0]        w_cnt_upd;
  logic [LANES*CNT_W-1:0]  w_cnt_new;
  logic [NDROP_W-1:0]      w_ndrop;
  logic [NUM_TILES-1:0]    w_nonempty;
  logic [NUM_TILES-1:0]    w_above;
  logic                    w_later;
  logic [CNT_W-1:0]        w_cur_cnt;
  logic                    w_cur_nonempty;
  logic                    w_tile_last;
  logic                    w_out_free;
  logic [ADDR_W-1:0]       w_rd_addr;

  assign in_ready = (r_state == FILL);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_lane_cnt = '0;
    w_ndrop    = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_cnt[i*CNT_W +: CNT_W] = r_cnt[in_tile_idx[i*TILE_W +: TILE_W]];
      w_ndrop = w_ndrop + NDROP_W'(w_drop[i]);
    end
  end

  tile_slot_allocator #(
    .NUM_TILES    (NUM_TILES),
    .PTS_PER_TILE (PTS_PER_TILE),
    .LANES        (LANES)
  ) u_alloc (
    .i_lane_en  (in_lane_en),
    .i_tile_idx (in_tile_idx),
    .i_lane_cnt (w_lane_cnt),
    .o_slot     (w_slot),
    .o_wr_en    (w_wr_en),
    .o_drop     (w_drop),
    .o_cnt_upd  (w_cnt_upd),
    .o_cnt_new  (w_cnt_new)
  );

  always_comb begin
    w_nonempty = '0;
    for (int t = 0; t < NUM_TILES; t++) w_nonempty[t] = (r_cnt[t] != '0);
  end

  assign w_above        = w_nonempty >> r_scan;
  assign w_later        = (w_above >> 1) != '0;
  assign w_cur_cnt      = r_cnt[r_scan];
  assign w_cur_nonempty = (w_cur_cnt != '0);
  assign w_tile_last    = ((r_slot + CNT_W'(1)) == w_cur_cnt);
  assign w_out_free     = !r_out_valid || out_ready;
  assign w_rd_addr      = {r_scan, r_slot[SLOT_W-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:  if (w_accept && in_frame_end) w_state_next = DRAIN;
      DRAIN: begin
        if (w_out_free && (r_scan_end || (!w_cur_nonempty && r_scan == LAST_TILE)))
          w_state_next = CLEAR;
      end
      CLEAR: w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  // NOTE: the point storage has no reset; only the tile counts decide what is valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_wr_en[i])
          r_mem[{in_tile_idx[i*TILE_W +: TILE_W], w_slot[i*SLOT_W +: SLOT_W]}] <= in_point[i*POINT_W +: POINT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NUM_TILES; t++) r_cnt[t] <= '0;
    end else if (r_state == CLEAR) begin
      for (int t = 0; t < NUM_TILES; t++) r_cnt[t] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_cnt_upd[i]) r_cnt[in_tile_idx[i*TILE_W +: TILE_W]] <= w_cnt_new[i*CNT_W +: CNT_W];
      end
    end
  end

  // The final count stays visible through the frame_done cycle and clears on the way back to FILL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_drop <= '0;
    else if (r_state == CLEAR) r_drop <= '0;
    else if (w_accept)         r_drop <= sat_add_drop(r_drop, 8'(w_ndrop));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan           <= '0;
      r_slot           <= '0;
      r_scan_end       <= 1'b0;
      r_out_valid      <= 1'b0;
      r_out_point      <= '0;
      r_out_tile       <= '0;
      r_out_tile_last  <= 1'b0;
      r_out_frame_last <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_scan      <= '0;
      r_slot      <= '0;
      r_scan_end  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (r_state == DRAIN && w_out_free) begin
      if (r_scan_end || !w_cur_nonempty) begin
        r_out_valid <= 1'b0;
        if (!r_scan_end) r_scan <= r_scan + TILE_W'(1);
      end else begin
        r_out_valid      <= 1'b1;
        r_out_point      <= r_mem[w_rd_addr];
        r_out_tile       <= r_scan;
        r_out_tile_last  <= w_tile_last;
        r_out_frame_last <= w_tile_last && !w_later;
        if (w_tile_last) begin
          r_slot <= '0;
          r_scan <= r_scan + TILE_W'(1);
          if (!w_later) r_scan_end <= 1'b1;
        end else begin
          r_slot <= r_slot + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_point      = r_out_point;
  assign out_tile       = r_out_tile;
  assign out_tile_last  = r_out_tile_last;
  assign out_frame_last = r_out_frame_last;
  assign frame_done     = (r_state == CLEAR);
  assign drop_count     = r_drop;

endmodule

// File: tb/tb_tile_point_buffer.sv
// Directed bench for tile_point_buffer: fill, drain order, overflow drops,
// empty frame scan, output back-pressure, tile boundaries and reset mid-drain.
module tb_tile_point_buffer;
  import lidar_tile_pkg::*;

  localparam int NT = 256;
  localparam int PPT = 32;
  localparam int PW = 32;
  localparam int LN = 4;
  localparam int TW = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [LN-1:0]    in_lane_en;
  logic [LN*TW-1:0] in_tile_idx;
  logic [LN*PW-1:0] in_point;
  logic             in_frame_end;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_point;
  logic [TW-1:0]    out_tile;
  logic             out_tile_last;
  logic             out_frame_last;
  logic             frame_done;
  logic [15:0]      drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  tile_point_buffer #(
    .NUM_TILES    (NT),
    .PTS_PER_TILE (PPT),
    .POINT_W      (PW),
    .LANES        (LN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_en     (in_lane_en),
    .in_tile_idx    (in_tile_idx),
    .in_point       (in_point),
    .in_frame_end   (in_frame_end),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_point      (out_point),
    .out_tile       (out_tile),
    .out_tile_last  (out_tile_last),
    .out_frame_last (out_frame_last),
    .frame_done     (frame_done),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one beat starting at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic [3:0] en,
                           input logic [7:0] t0, input logic [7:0] t1,
                           input logic [7:0] t2, input logic [7:0] t3,
                           input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3,
                           input logic fe);
    in_lane_en   = en;
    in_tile_idx  = {t3, t2, t1, t0};
    in_point     = {p3, p2, p1, p0};
    in_frame_end = fe;
    in_valid     = 1'b1;
    for (int k = 0; k < 600 && !in_ready; k++) @(negedge clk);
    if (!in_ready) check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid     = 1'b0;
    in_frame_end = 1'b0;
    in_lane_en   = '0;
  endtask

  // Waits for a drained point (out_ready held high) and checks it.
  task automatic expect_pt(input string tag, input logic [31:0] p, input logic [7:0] t,
                           input logic tl, input logic fl);
    for (int k = 0; k < 1000 && !out_valid; k++) @(negedge clk);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_point"}, out_point, p);
    check({tag, "_meta"}, {22'b0, out_tile, out_tile_last, out_frame_last}, {22'b0, t, tl, fl});
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input logic [15:0] exp_drop);
    for (int k = 0; k < 2000 && !frame_done; k++) @(negedge clk);
    check({tag, "_done"}, {31'b0, frame_done}, 32'd1);
    check({tag, "_drop_at_done"}, {16'b0, drop_count}, {16'b0, exp_drop});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, frame_done}, 32'd0);
    check({tag, "_drop_fill"}, {16'b0, drop_count}, 32'd0);
    check({tag, "_ready_fill"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_p [6];
    logic [7:0]  exp_t [6];
    logic [5:0]  exp_tl;
    logic [5:0]  exp_fl;
    logic        rdy;
    logic        stalled;
    logic        seen;
    logic [31:0] held_p;
    logic [7:0]  held_t;
    int          idx;
    int          cyc;

    reset        = 1'b1;
    in_valid     = 1'b0;
    in_lane_en   = '0;
    in_tile_idx  = '0;
    in_point     = '0;
    in_frame_end = 1'b0;
    out_ready    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_drop", {16'b0, drop_count}, 32'd0);
    check("rst_out_point", out_point, 32'd0);
    check("rst_out_meta", {22'b0, out_tile, out_tile_last, out_frame_last}, 32'd0);

    // T1: one beat, three lanes on tile 5, one on tile 9
    send_beat(4'b1111, 8'd5, 8'd9, 8'd5, 8'd5, 32'hA, 32'hB, 32'hC, 32'hD, 1'b1);
    check("t1_latency", {31'b0, out_valid}, 32'd0);
    check("t1_in_ready_drain", {31'b0, in_ready}, 32'd0);
    expect_pt("t1_a", 32'hA, 8'd5, 1'b0, 1'b0);
    expect_pt("t1_c", 32'hC, 8'd5, 1'b0, 1'b0);
    expect_pt("t1_d", 32'hD, 8'd5, 1'b1, 1'b0);
    expect_pt("t1_b", 32'hB, 8'd9, 1'b1, 1'b1);
    wait_done("t1", 16'd0);

    // T2: 40 points to tile 7, 8 overflow drops
    for (int k = 0; k < 40; k++)
      send_beat(4'b0001, 8'd7, 8'd0, 8'd0, 8'd0, 32'h100 + 32'(k), 32'h0, 32'h0, 32'h0, k == 39);
    for (int s = 0; s < 32; s++)
      expect_pt("t2", 32'h100 + 32'(s), 8'd7, s == 31, s == 31);
    wait_done("t2", 16'd8);

    // T3: empty frame, scan of every tile with no output
    send_beat(4'b0000, 8'd1, 8'd2, 8'd3, 8'd4, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1);
    seen = 1'b0;
    cyc  = 0;
    while (!frame_done && cyc < 2000) begin
      seen = seen | out_valid;
      @(negedge clk);
      cyc++;
    end
    check("t3_no_valid", {31'b0, seen}, 32'd0);
    check("t3_scan_cycles", 32'(cyc), 32'(NT));
    wait_done("t3", 16'd0);

    // T4: back-pressure with out_ready toggling every cycle
    send_beat(4'b1111, 8'd2, 8'd2, 8'd2, 8'd2, 32'h200, 32'h201, 32'h202, 32'h203, 1'b0);
    send_beat(4'b0011, 8'd4, 8'd2, 8'd0, 8'd0, 32'h400, 32'h204, 32'h0, 32'h0, 1'b1);
    exp_p  = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'h400};
    exp_t  = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd4};
    exp_tl = 6'b110000;
    exp_fl = 6'b100000;
    rdy     = 1'b0;
    stalled = 1'b0;
    held_p  = '0;
    held_t  = '0;
    idx     = 0;
    cyc     = 0;
    while (idx < 6 && cyc < 3000) begin
      if (stalled) begin
        check("t4_hold_valid", {31'b0, out_valid}, 32'd1);
        check("t4_hold_point", out_point, held_p);
        check("t4_hold_tile", {24'b0, out_tile}, {24'b0, held_t});
      end
      rdy = ~rdy;
      out_ready = rdy;
      if (out_valid && rdy) begin
        check("t4_point", out_point, exp_p[idx]);
        check("t4_meta", {22'b0, out_tile, out_tile_last, out_frame_last},
              {22'b0, exp_t[idx], exp_tl[idx], exp_fl[idx]});
        idx++;
      end
      stalled = out_valid && !rdy;
      held_p  = out_point;
      held_t  = out_tile;
      @(negedge clk);
      cyc++;
    end
    check("t4_count", 32'(idx), 32'd6);
    out_ready = 1'b1;
    wait_done("t4", 16'd0);

    // T5: first and last tile
    send_beat(4'b0011, 8'd255, 8'd0, 8'd0, 8'd0, 32'hFF, 32'hAA, 32'h0, 32'h0, 1'b1);
    expect_pt("t5_tile0", 32'hAA, 8'd0, 1'b1, 1'b0);
    expect_pt("t5_tile255", 32'hFF, 8'd255, 1'b1, 1'b1);
    wait_done("t5", 16'd0);

    // T6: reset during drain aborts the frame
    send_beat(4'b1111, 8'd10, 8'd10, 8'd10, 8'd10, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b1);
    for (int k = 0; k < 1000 && !out_valid; k++) @(negedge clk);
    check("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    check("t6_pre_point", out_point, 32'hA0);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_beat(4'b0001, 8'd3, 8'd0, 8'd0, 8'd0, 32'h333, 32'h0, 32'h0, 32'h0, 1'b1);
    expect_pt("t6_only", 32'h333, 8'd3, 1'b1, 1'b1);
    wait_done("t6", 16'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    check("t6_quiet", {31'b0, seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
